// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter: FSM state
// encoding, requester identifiers and the counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_t;

  // Largest supported number of memory access cycles per transaction.
  localparam int WAIT_CYC_MAX = 15;

  // Wait counter width: enough to hold wait_cyc, never less than one bit.
  function automatic int cnt_width(input int wait_cyc);
    if (wait_cyc < 1) return 1;
    return $clog2(wait_cyc + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, DMA port, memory port and status signals of the
// memory port arbiter. The arbiter uses the slave view; requesters and the
// memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  // CPU requester
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;

  // DMA / loader requester
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_ack;

  // Unified memory
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Status
  logic              busy;
  logic              grant_dma;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output busy, grant_dma
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  busy, grant_dma
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and DMA requesters.
// Build option MEM_ARB_RR_EN: when defined, a contested cycle goes to the
// requester that did not win last time (round-robin); when undefined, the
// CPU always wins a contested cycle (fixed priority).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic    cpu_req_i,
  input  logic    dma_req_i,
  input  req_id_t last_grant_i,
  output logic    any_req_o,
  output req_id_t winner_o
);

`ifndef MEM_ARB_RR_EN
  // last_grant is tracked by the arbiter in every build; only round-robin
  // consults it.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

  // Pick the winner; a lone requester always wins.
  always_comb begin
    // NOTE: outputs get a value before any branch, so no path leaves them
    // unassigned and no latch is inferred.
    any_req_o = cpu_req_i | dma_req_i;
    winner_o  = REQ_CPU;
    if (cpu_req_i && dma_req_i) begin
`ifdef MEM_ARB_RR_EN
      winner_o = (last_grant_i == REQ_CPU) ? REQ_DMA : REQ_CPU;
`else
      winner_o = REQ_CPU;
`endif
    end else if (dma_req_i) begin
      winner_o = REQ_DMA;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the CPU controller port and a DMA port.
// One transaction at a time: the winner's payload is latched in IDLE, the
// memory is driven for WAIT_CYC cycles in ACCESS, and a one-cycle ack is
// returned in RESP. Build option MEM_ARB_RR_EN (see mem_arb_pick) selects
// round-robin instead of fixed CPU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input logic              clk,
  input logic              rst,
  mem_port_arbiter_if.slave bus
);

  // Out-of-range WAIT_CYC values saturate to the supported 1..WAIT_CYC_MAX.
  localparam int WAIT_EFF = (WAIT_CYC < 1) ? 1 :
                            ((WAIT_CYC > WAIT_CYC_MAX) ? WAIT_CYC_MAX : WAIT_CYC);
  localparam int CNT_W = cnt_width(WAIT_EFF);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_EFF - 1);

  state_t            state_q, state_d;
  req_id_t           grant_q, grant_d;
  req_id_t           last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;

  logic              any_req;
  req_id_t           winner;

  mem_arb_pick u_pick (
    .cpu_req_i    (bus.cpu_req),
    .dma_req_i    (bus.dma_req),
    .last_grant_i (last_grant_q),
    .any_req_o    (any_req),
    .winner_o     (winner)
  );

  // State register; reset aborts any transaction without an ack.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples its next
    // value from the same edge, independent of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, payload latch, wait counter and read-data capture.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = winner;
          cnt_d   = CNT_LOAD;
          state_d = ACCESS;
          if (winner == REQ_DMA) begin
            we_d    = bus.dma_we;
            addr_d  = bus.dma_addr;
            wdata_d = bus.dma_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          // Read data is valid on the last access cycle; only the winner's
          // register is touched.
          if (!we_q) begin
            if (grant_q == REQ_DMA) dma_rdata_d = bus.mem_rdata;
            else                    cpu_rdata_d = bus.mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers: latched payload, winner, history, counter, rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q      <= REQ_CPU;
      last_grant_q <= REQ_DMA;   // CPU wins the first contested cycle
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  // Outputs decode directly from the state register, so an asynchronous
  // reset drops mem_en/mem_we and the acks immediately.
  assign bus.mem_en    = (state_q == ACCESS);
  assign bus.mem_we    = (state_q == ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.grant_dma = (grant_q == REQ_DMA);
  assign bus.cpu_ack   = (state_q == RESP) && (grant_q == REQ_CPU);
  assign bus.dma_ack   = (state_q == RESP) && (grant_q == REQ_DMA);
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of single transactions
// on a WAIT_CYC=2 instance, hand sequences for contention, grant order,
// mid-transaction reset, and a WAIT_CYC=1 instance. Completed transactions
// are checked against a scoreboard queue filled when requests are driven.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYC(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  // Word-addressed memory model behind the WAIT_CYC=2 instance.
  bit [31:0] tb_mem [0:255];
  bit        mem_loaded = 1'b0;
  assign bus.mem_rdata = tb_mem[bus.mem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      tb_mem[8'h10] <= 32'hDEADBEEF;   // 0x40
      tb_mem[8'h80] <= 32'h5555AAAA;   // 0x200
      mem_loaded    <= 1'b1;
    end else if (bus.mem_en && bus.mem_we) begin
      tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    end
  end

  // The WAIT_CYC=1 instance sees a fixed pattern at 0x80.
  assign bus1.mem_rdata = (bus1.mem_addr == 32'h80) ? 32'hA5A5A5A5 : 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb [$];

  typedef struct {
    bit          dma;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [7];

  logic [31:0] exp_cpu_rdata = '0;
  logic [31:0] exp_dma_rdata = '0;
  bit   [3:0]  exp_grants;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Pop and compare on every ack; reset clears the expected rdata registers.
  task automatic monitor();
    sb_t e;
    if (rst) begin
      exp_cpu_rdata = '0;
      exp_dma_rdata = '0;
    end else if (bus.cpu_ack || bus.dma_ack) begin
      check("ack_exclusive", {31'b0, bus.cpu_ack & bus.dma_ack}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got ack cpu=%0b dma=%0b, expected no ack",
                 bus.cpu_ack, bus.dma_ack);
      end else begin
        e = sb.pop_front();
        check("ack_owner", {31'b0, bus.dma_ack}, {31'b0, e.dma});
        if (!e.we) begin
          if (e.dma) exp_dma_rdata = e.rdata;
          else       exp_cpu_rdata = e.rdata;
        end
        check("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
        check("dma_rdata", bus.dma_rdata, exp_dma_rdata);
      end
    end
  endtask

  // One cycle: sample at the falling edge, then let the caller drive.
  task automatic step();
    @(negedge clk);
    monitor();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single transaction with cycle-exact checks; payload is scrambled once
  // the request has been taken.
  task automatic run_txn(input bit dma, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    sb_t e;
    step();
    check("idle_busy", {31'b0, bus.busy}, 32'h0);
    check("idle_mem_en", {31'b0, bus.mem_en}, 32'h0);
    if (dma) begin
      bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    e.dma = dma; e.we = we; e.rdata = exp_rdata;
    sb.push_back(e);
    for (int cyc = 1; cyc <= W + 1; cyc++) begin
      step();
      check($sformatf("c%0d_mem_en", cyc), {31'b0, bus.mem_en}, {31'b0, cyc <= W});
      check($sformatf("c%0d_busy", cyc), {31'b0, bus.busy}, 32'h1);
      check($sformatf("c%0d_ack", cyc), {31'b0, dma ? bus.dma_ack : bus.cpu_ack},
            {31'b0, cyc == W + 1});
      if (cyc <= W) begin
        check("mem_addr", bus.mem_addr, addr);
        check("mem_we", {31'b0, bus.mem_we}, {31'b0, we});
        if (we) check("mem_wdata", bus.mem_wdata, wdata);
      end
      if (cyc == 1) begin
        check("grant_dma", {31'b0, bus.grant_dma}, {31'b0, dma});
        if (dma) begin
          bus.dma_we = ~we; bus.dma_addr = ~addr; bus.dma_wdata = ~wdata;
        end else begin
          bus.cpu_we = ~we; bus.cpu_addr = ~addr; bus.cpu_wdata = ~wdata;
        end
      end
    end
    if (dma) bus.dma_req = 1'b0;
    else     bus.cpu_req = 1'b0;
  endtask

  initial begin
    sb_t e;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_addr = '0; bus.dma_wdata = '0;
    bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.dma_req = 1'b0; bus1.dma_we = 1'b0; bus1.dma_addr = '0; bus1.dma_wdata = '0;
    rst = 1'b1;

    //          dma   we    addr       wdata         exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 32'h100, 32'h00001234, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h00001234};
    vecs[3] = '{1'b0, 1'b1, 32'h40,  32'hCAFEF00D, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b0, 32'h40,  32'h0,        32'hCAFEF00D};
    vecs[6] = '{1'b0, 1'b0, 32'h200, 32'h0,        32'h5555AAAA};

    // Reset values, sampled while reset is held.
    step();
    step();
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    check("rst_dma_ack", {31'b0, bus.dma_ack}, 32'h0);
    check("rst_cpu_rdata", bus.cpu_rdata, 32'h0);
    check("rst_dma_rdata", bus.dma_rdata, 32'h0);
    check("rst_grant_dma", {31'b0, bus.grant_dma}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

    // Both request at cycle 0: CPU acked in 3, DMA granted in IDLE at 4, acked in 7.
    do_reset();
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
    bus.dma_req = 1'b1; bus.dma_we = 1'b0; bus.dma_addr = 32'h100;
    e.dma = 1'b0; e.we = 1'b0; e.rdata = 32'hCAFEF00D; sb.push_back(e);
    e.dma = 1'b1; e.we = 1'b0; e.rdata = 32'h00001234; sb.push_back(e);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      check($sformatf("both_c%0d_cpu_ack", cyc), {31'b0, bus.cpu_ack}, {31'b0, cyc == 3});
      check($sformatf("both_c%0d_dma_ack", cyc), {31'b0, bus.dma_ack}, {31'b0, cyc == 7});
      check($sformatf("both_c%0d_busy", cyc), {31'b0, bus.busy},
            {31'b0, (cyc != 4) && (cyc <= 7)});
      if (cyc == 1) check("both_grant_cpu", {31'b0, bus.grant_dma}, 32'h0);
      if (cyc == 5) begin
        check("both_grant_dma", {31'b0, bus.grant_dma}, 32'h1);
        check("both_dma_addr", bus.mem_addr, 32'h100);
      end
      if (cyc == 3) bus.cpu_req = 1'b0;
      if (cyc == 7) bus.dma_req = 1'b0;
    end

    // Both held for four transactions: grant order depends on the build.
`ifdef MEM_ARB_RR_EN
    exp_grants = 4'b1010;
`else
    exp_grants = 4'b0000;
`endif
    do_reset();
    step();
    bus.cpu_req = 1'b1; bus.dma_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      e.dma = exp_grants[k]; e.we = 1'b0;
      e.rdata = exp_grants[k] ? 32'h00001234 : 32'hCAFEF00D;
      sb.push_back(e);
    end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      step();
      if (cyc % 4 == 1)
        check($sformatf("rr_grant_%0d", cyc / 4), {31'b0, bus.grant_dma},
              {31'b0, exp_grants[cyc / 4]});
      if (cyc == 15) begin
        bus.cpu_req = 1'b0; bus.dma_req = 1'b0;
      end
      if (cyc == 16) check("rr_idle_busy", {31'b0, bus.busy}, 32'h0);
    end

    // Reset in the second ACCESS cycle of a CPU write.
    step();
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h300; bus.cpu_wdata = 32'hBAD0BAD0;
    step();
    check("abort_c1_mem_en", {31'b0, bus.mem_en}, 32'h1);
    @(posedge clk);
    #1;
    check("abort_c2_mem_en", {31'b0, bus.mem_en}, 32'h1);
    rst = 1'b1;
    #1;
    check("abort_mem_en", {31'b0, bus.mem_en}, 32'h0);
    check("abort_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    step();
    check("abort_cpu_ack", {31'b0, bus.cpu_ack}, 32'h0);
    step();
    rst = 1'b0;
    step();
    check("abort_post_ack", {31'b0, bus.cpu_ack}, 32'h0);
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, 32'hCAFEF00D);

    // WAIT_CYC=1 instance: one ACCESS cycle, ack in cycle 2.
    step();
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 32'h80;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      step();
      check($sformatf("w1_c%0d_mem_en", cyc), {31'b0, bus1.mem_en}, {31'b0, cyc == 1});
      check($sformatf("w1_c%0d_cpu_ack", cyc), {31'b0, bus1.cpu_ack}, {31'b0, cyc == 2});
      check($sformatf("w1_c%0d_dma_ack", cyc), {31'b0, bus1.dma_ack}, 32'h0);
      if (cyc == 1) check("w1_mem_addr", bus1.mem_addr, 32'h80);
      if (cyc == 2) begin
        check("w1_cpu_rdata", bus1.cpu_rdata, 32'hA5A5A5A5);
        bus1.cpu_req = 1'b0;
      end
      if (cyc == 3) check("w1_busy", {31'b0, bus1.busy}, 32'h0);
    end

    step();
    check("sb_drain", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory between the multi-cycle CPU controller port and a DMA/loader port.
- Accepts one request at a time, latches its address, write enable and write data, and holds the memory access for a fixed number of wait cycles.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the CPU datapath memory mux (IorD path) and the memory model; the CPU controller stalls on its memory states until cpu_ack.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- WAIT_CYC, 2, memory access cycles per transaction; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU request; held with its payload until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  registered CPU read data
- cpu_ack  out  1  one-cycle completion pulse to CPU
- dma_req, dma_we, dma_addr, dma_wdata, dma_rdata, dma_ack: same widths and meaning, DMA side
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid during ACCESS
- busy  out  1  high when state is not IDLE
- grant_dma  out  1  latched winner: 0 = CPU, 1 = DMA

Behaviour:
- Reset values:
  - State = IDLE; all acks, mem_en, mem_we, busy and grant_dma = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
  - Wait counter = 0; last_grant = DMA, so the CPU wins first.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req is high, pick the winner, latch its we/addr/wdata, set grant_dma, load counter = WAIT_CYC-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - mem_en = 1 and mem_we = latched we, for exactly WAIT_CYC cycles.
  - mem_addr and mem_wdata are held stable from the latch.
  - The counter decrements each cycle. At counter == 0: on a read, capture mem_rdata into the winner's rdata register; then go to RESP.
- RESP:
  - Winner's ack = 1 for exactly one cycle; mem_en = 0.
  - Update last_grant, then go to IDLE.
- Latency: a req first seen in IDLE at cycle 0 sees its ack in cycle WAIT_CYC+1, i.e. cycle 3 at the default.
- Back-to-back throughput is one transaction per WAIT_CYC+2 cycles, because every transaction passes through IDLE.
- Requests are sampled only in IDLE. A req still high in the IDLE cycle after its ack is a new transaction, so requesters drop req on the edge where they see ack.
- Payload changes while not in IDLE are ignored, because the payload is latched.
- Each rdata register changes only on its own requester's read completion. Writes and the other requester's traffic leave it unchanged.
- Default arbitration is fixed priority: CPU wins whenever both requests are high.
- Acks are mutually exclusive; at most one ack is high in any cycle.
- Reset mid-operation (rst in ACCESS or RESP):
  - State returns to IDLE immediately and mem_en/mem_we drop asynchronously.
  - No ack is issued; the aborted write may be partial.
- WAIT_CYC = 1: ACCESS lasts one cycle; the counter loads 0.
- Counter width is $clog2(WAIT_CYC+1), minimum 1 bit.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the requester that is not last_grant. A single requester always wins regardless of last_grant.
- Undefined: fixed CPU priority. last_grant is still maintained but unused, and DMA can starve under continuous CPU requests.

Decomposition:
- Package mem_arb_pkg:
  - State encoding: IDLE = 2'b00, ACCESS = 2'b01, RESP = 2'b10.
  - Requester IDs: REQ_CPU = 1'b0, REQ_DMA = 1'b1.
  - Legal WAIT_CYC maximum constant.
- One sub-module, mem_arb_pick: combinational winner select from cpu_req, dma_req and last_grant. It contains the MEM_ARB_RR_EN conditional.
- FSM, latches and counter stay in mem_port_arbiter.

Test Plan:
- CPU read, addr 0x40, mem_rdata 0xDEADBEEF, WAIT_CYC = 2 -> mem_en high in cycles 1-2 with mem_addr = 0x40, mem_we = 0; cpu_ack in cycle 3; cpu_rdata = 0xDEADBEEF; dma_ack stays 0.
- DMA write, addr 0x100, data 0x00001234 -> mem_en = mem_we = 1 in cycles 1-2 with mem_wdata = 0x1234; dma_ack in cycle 3; cpu_rdata and dma_rdata unchanged.
- Both requests high at cycle 0, fixed priority -> cpu_ack in cycle 3; DMA granted in IDLE at cycle 4; dma_ack in cycle 7; acks never overlap.
- MEM_ARB_RR_EN defined, both requests re-asserted after each ack for 4 transactions -> grant_dma sequence 0, 1, 0, 1. Undefined -> 0, 0, 0, 0.
- rst pulsed in the second ACCESS cycle of a CPU write -> mem_en = 0 within the same cycle, no cpu_ack, busy = 0. After release, a new CPU read completes normally in 3 cycles.
- WAIT_CYC = 1, CPU read of 0xA5A5A5A5 -> mem_en for exactly 1 cycle; cpu_ack in cycle 2 with cpu_rdata = 0xA5A5A5A5.
